// File: rtl/axi_read_arbiter.sv
// Two-master AXI4 read arbiter: shares one slave AR/R port between M0 (fetch) and M1 (data),
// with round-robin on ties and a single read transaction in flight at a time.
module axi_read_arbiter #(
  parameter int ID_W  = 4,
  parameter int IDS_W = 8
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  // M0 (instruction fetch)
  input  logic [ID_W-1:0]  M0_ARID,
  input  logic [31:0]      M0_ARADDR,
  input  logic [3:0]       M0_ARLEN,
  input  logic [2:0]       M0_ARSIZE,
  input  logic [1:0]       M0_ARBURST,
  input  logic             M0_ARVALID,
  output logic             M0_ARREADY,
  output logic [ID_W-1:0]  M0_RID,
  output logic [31:0]      M0_RDATA,
  output logic [1:0]       M0_RRESP,
  output logic             M0_RLAST,
  output logic             M0_RVALID,
  input  logic             M0_RREADY,
  // M1 (data access)
  input  logic [ID_W-1:0]  M1_ARID,
  input  logic [31:0]      M1_ARADDR,
  input  logic [3:0]       M1_ARLEN,
  input  logic [2:0]       M1_ARSIZE,
  input  logic [1:0]       M1_ARBURST,
  input  logic             M1_ARVALID,
  output logic             M1_ARREADY,
  output logic [ID_W-1:0]  M1_RID,
  output logic [31:0]      M1_RDATA,
  output logic [1:0]       M1_RRESP,
  output logic             M1_RLAST,
  output logic             M1_RVALID,
  input  logic             M1_RREADY,
  // SRAM slave
  output logic [IDS_W-1:0] S_ARID,
  output logic [31:0]      S_ARADDR,
  output logic [3:0]       S_ARLEN,
  output logic [2:0]       S_ARSIZE,
  output logic [1:0]       S_ARBURST,
  output logic             S_ARVALID,
  input  logic             S_ARREADY,
  input  logic [IDS_W-1:0] S_RID,
  input  logic [31:0]      S_RDATA,
  input  logic [1:0]       S_RRESP,
  input  logic             S_RLAST,
  input  logic             S_RVALID,
  output logic             S_RREADY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;

  logic            sel_arvalid;
  logic [ID_W-1:0] sel_arid;
  logic [31:0]     sel_araddr;
  logic [3:0]      sel_arlen;
  logic [2:0]      sel_arsize;
  logic [1:0]      sel_arburst;
  logic            sel_rready;

  assign sel_arvalid = grant_q ? M1_ARVALID : M0_ARVALID;
  assign sel_arid    = grant_q ? M1_ARID    : M0_ARID;
  assign sel_araddr  = grant_q ? M1_ARADDR  : M0_ARADDR;
  assign sel_arlen   = grant_q ? M1_ARLEN   : M0_ARLEN;
  assign sel_arsize  = grant_q ? M1_ARSIZE  : M0_ARSIZE;
  assign sel_arburst = grant_q ? M1_ARBURST : M0_ARBURST;
  assign sel_rready  = grant_q ? M1_RREADY  : M0_RREADY;

  // Routing relies on grant_q alone; the grant bit echoed in S_RID is deliberately ignored.
  logic unused_rid_hi;
  assign unused_rid_hi = ^S_RID[IDS_W-1:ID_W];

  // last_grant resets to M1 so that M0 wins the first tie.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;

    M0_ARREADY = 1'b0; M0_RID = '0; M0_RDATA = '0; M0_RRESP = '0; M0_RLAST = 1'b0; M0_RVALID = 1'b0;
    M1_ARREADY = 1'b0; M1_RID = '0; M1_RDATA = '0; M1_RRESP = '0; M1_RLAST = 1'b0; M1_RVALID = 1'b0;
    S_ARID = '0; S_ARADDR = '0; S_ARLEN = '0; S_ARSIZE = '0; S_ARBURST = '0;
    S_ARVALID = 1'b0; S_RREADY = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (M0_ARVALID || M1_ARVALID) begin
          state_d = ADDR;
          if (M0_ARVALID && M1_ARVALID) grant_d = ~last_grant_q;
          else                          grant_d = M1_ARVALID;
        end
      end

      ADDR: begin
        S_ARVALID            = sel_arvalid;
        S_ARID[ID_W]         = grant_q;
        S_ARID[ID_W-1:0]     = sel_arid;
        S_ARADDR             = sel_araddr;
        S_ARLEN              = sel_arlen;
        S_ARSIZE             = sel_arsize;
        S_ARBURST            = sel_arburst;
        if (grant_q) M1_ARREADY = S_ARREADY;
        else         M0_ARREADY = S_ARREADY;
        if (sel_arvalid && S_ARREADY) begin
          last_grant_d = grant_q;
          state_d      = DATA;
        end
      end

      DATA: begin
        S_RREADY = sel_rready;
        if (grant_q) begin
          M1_RVALID = S_RVALID; M1_RID = S_RID[ID_W-1:0]; M1_RDATA = S_RDATA;
          M1_RRESP  = S_RRESP;  M1_RLAST = S_RLAST;
        end else begin
          M0_RVALID = S_RVALID; M0_RID = S_RID[ID_W-1:0]; M0_RDATA = S_RDATA;
          M0_RRESP  = S_RRESP;  M0_RLAST = S_RLAST;
        end
        if (S_RVALID && sel_rready && S_RLAST) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: the bench plays both masters and the SRAM slave,
// with expected values written out by hand for each scenario.
module tb_axi_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  M0_ARID = '0, M1_ARID = '0;
  logic [31:0] M0_ARADDR = '0, M1_ARADDR = '0;
  logic [3:0]  M0_ARLEN = '0, M1_ARLEN = '0;
  logic [2:0]  M0_ARSIZE = '0, M1_ARSIZE = '0;
  logic [1:0]  M0_ARBURST = '0, M1_ARBURST = '0;
  logic        M0_ARVALID = 1'b0, M1_ARVALID = 1'b0;
  logic        M0_ARREADY, M1_ARREADY;
  logic [3:0]  M0_RID, M1_RID;
  logic [31:0] M0_RDATA, M1_RDATA;
  logic [1:0]  M0_RRESP, M1_RRESP;
  logic        M0_RLAST, M1_RLAST, M0_RVALID, M1_RVALID;
  logic        M0_RREADY = 1'b0, M1_RREADY = 1'b0;
  logic [7:0]  S_ARID;
  logic [31:0] S_ARADDR;
  logic [3:0]  S_ARLEN;
  logic [2:0]  S_ARSIZE;
  logic [1:0]  S_ARBURST;
  logic        S_ARVALID;
  logic        S_ARREADY = 1'b0;
  logic [7:0]  S_RID = '0;
  logic [31:0] S_RDATA = '0;
  logic [1:0]  S_RRESP = '0;
  logic        S_RLAST = 1'b0, S_RVALID = 1'b0;
  logic        S_RREADY;

  int checks = 0;
  int errors = 0;
  logic [31:0] m0_beats[$];

  always #5 ACLK = ~ACLK;

  axi_read_arbiter #(.ID_W(4), .IDS_W(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M0_ARID(M0_ARID), .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARSIZE(M0_ARSIZE),
    .M0_ARBURST(M0_ARBURST), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RID(M0_RID), .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RLAST(M0_RLAST),
    .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_ARID(M1_ARID), .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARSIZE(M1_ARSIZE),
    .M1_ARBURST(M1_ARBURST), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RID(M1_RID), .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RLAST(M1_RLAST),
    .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
    .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  // Record every beat M0 actually accepts, to detect loss or duplication.
  always @(posedge ACLK) begin
    if (M0_RVALID && M0_RREADY) m0_beats.push_back(M0_RDATA);
  end

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic slave_beat(input logic [31:0] data, input logic [7:0] rid, input logic last);
    S_RVALID = 1'b1; S_RDATA = data; S_RID = rid; S_RLAST = last; S_RRESP = 2'b00;
  endtask

  task automatic slave_idle();
    S_RVALID = 1'b0; S_RDATA = '0; S_RID = '0; S_RLAST = 1'b0;
  endtask

  task automatic test_reset();
    M0_ARVALID = 1'b1; M0_ARID = 4'h5; M0_ARADDR = 32'h0000_0100; M0_ARLEN = 4'd0;
    M0_RREADY = 1'b1;
    repeat (3) tick();
    #1;
    checks++; if (S_ARVALID !== 1'b0) begin errors++; $display("FAIL rst_s_arvalid got=%0h exp=0", S_ARVALID); end
    checks++; if (M0_ARREADY !== 1'b0) begin errors++; $display("FAIL rst_m0_arready got=%0h exp=0", M0_ARREADY); end
    checks++; if (S_ARADDR !== 32'h0) begin errors++; $display("FAIL rst_s_araddr got=%h exp=0", S_ARADDR); end
    checks++; if (S_RREADY !== 1'b0 || M0_RVALID !== 1'b0) begin errors++; $display("FAIL rst_r_chan got=%0h%0h exp=00", S_RREADY, M0_RVALID); end
    ARESETn = 1'b1;
    #1;
    checks++; if (S_ARVALID !== 1'b0) begin errors++; $display("FAIL rst_idle_arvalid got=%0h exp=0", S_ARVALID); end
    tick();
    checks++; if (S_ARVALID !== 1'b1) begin errors++; $display("FAIL rst_first_arvalid got=%0h exp=1", S_ARVALID); end
    checks++; if (S_ARID !== 8'h05) begin errors++; $display("FAIL rst_s_arid got=%h exp=05", S_ARID); end
    checks++; if (S_ARADDR !== 32'h0000_0100) begin errors++; $display("FAIL rst_fwd_addr got=%h exp=00000100", S_ARADDR); end
    S_ARREADY = 1'b1;
    #1;
    checks++; if (M0_ARREADY !== 1'b1) begin errors++; $display("FAIL rst_m0_arready_hs got=%0h exp=1", M0_ARREADY); end
    tick();
    M0_ARVALID = 1'b0; S_ARREADY = 1'b0;
    slave_beat(32'hAAAA_0001, 8'h05, 1'b1);
    #1;
    checks++; if (M0_RVALID !== 1'b1 || M0_RDATA !== 32'hAAAA_0001 || M0_RID !== 4'h5) begin
      errors++; $display("FAIL rst_beat got=%0h/%h/%h exp=1/aaaa0001/5", M0_RVALID, M0_RDATA, M0_RID); end
    tick();
    slave_idle();
    #1;
    checks++; if (S_RREADY !== 1'b0) begin errors++; $display("FAIL rst_back_idle got=%0h exp=0", S_RREADY); end
    $display("txn reset: M0 read addr=00000100 len=0 done");
  endtask

  task automatic test_single_m1();
    M1_ARVALID = 1'b1; M1_ARADDR = 32'h0000_0040; M1_ARLEN = 4'd3; M1_ARID = 4'h2;
    M1_ARSIZE = 3'd2; M1_ARBURST = 2'b01; M1_RREADY = 1'b1;
    tick();
    checks++; if (S_ARVALID !== 1'b1 || S_ARID !== 8'h12) begin errors++; $display("FAIL m1_arid got=%0h/%h exp=1/12", S_ARVALID, S_ARID); end
    checks++; if (S_ARADDR !== 32'h40 || S_ARLEN !== 4'd3 || S_ARSIZE !== 3'd2 || S_ARBURST !== 2'b01) begin
      errors++; $display("FAIL m1_payload got=%h/%0d/%0d/%0d exp=00000040/3/2/1", S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST); end
    S_ARREADY = 1'b1;
    #1;
    checks++; if (M1_ARREADY !== 1'b1 || M0_ARREADY !== 1'b0) begin errors++; $display("FAIL m1_arready got=%0h%0h exp=10", M1_ARREADY, M0_ARREADY); end
    tick();
    M1_ARVALID = 1'b0; S_ARREADY = 1'b0;
    for (int b = 0; b < 4; b++) begin
      slave_beat(32'h0000_1000 + b, 8'h12, (b == 3));
      #1;
      checks++; if (M1_RVALID !== 1'b1 || M1_RDATA !== (32'h0000_1000 + b) || M1_RID !== 4'h2 || M1_RLAST !== (b == 3)) begin
        errors++; $display("FAIL m1_beat%0d got=%0h/%h/%h/%0h exp=1/%h/2/%0h", b, M1_RVALID, M1_RDATA, M1_RID, M1_RLAST, 32'h1000 + b, (b == 3)); end
      checks++; if (M0_RVALID !== 1'b0) begin errors++; $display("FAIL m1_m0_quiet%0d got=%0h exp=0", b, M0_RVALID); end
      tick();
    end
    slave_idle();
    #1;
    checks++; if (S_RREADY !== 1'b0 || M1_RVALID !== 1'b0) begin errors++; $display("FAIL m1_end_idle got=%0h%0h exp=00", S_RREADY, M1_RVALID); end
    $display("txn single_m1: addr=00000040 len=3 4 beats");
  endtask

  task automatic test_tie();
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    M0_ARID = 4'h1; M0_ARADDR = 32'h0000_0200; M0_ARLEN = 4'd0; M0_RREADY = 1'b1;
    M1_ARID = 4'h3; M1_ARADDR = 32'h0000_0300; M1_ARLEN = 4'd0; M1_RREADY = 1'b1;
    for (int t = 0; t < 2; t++) begin
      M0_ARVALID = 1'b1; M1_ARVALID = 1'b1;
      tick();
      checks++; if (S_ARID !== 8'h01 || S_ARADDR !== 32'h200) begin errors++; $display("FAIL tie%0d_m0_first got=%h/%h exp=01/00000200", t, S_ARID, S_ARADDR); end
      S_ARREADY = 1'b1;
      #1;
      checks++; if (M1_ARREADY !== 1'b0) begin errors++; $display("FAIL tie%0d_m1_held got=%0h exp=0", t, M1_ARREADY); end
      tick();
      M0_ARVALID = 1'b0; S_ARREADY = 1'b0;
      slave_beat(32'hB000_0000 + t, 8'h01, 1'b1);
      #1;
      checks++; if (M0_RVALID !== 1'b1 || M1_RVALID !== 1'b0) begin errors++; $display("FAIL tie%0d_m0_beat got=%0h%0h exp=10", t, M0_RVALID, M1_RVALID); end
      tick();
      slave_idle();
      #1;
      checks++; if (S_ARVALID !== 1'b0) begin errors++; $display("FAIL tie%0d_bubble got=%0h exp=0", t, S_ARVALID); end
      tick();
      checks++; if (S_ARVALID !== 1'b1 || S_ARID !== 8'h13) begin errors++; $display("FAIL tie%0d_m1_second got=%0h/%h exp=1/13", t, S_ARVALID, S_ARID); end
      S_ARREADY = 1'b1;
      tick();
      M1_ARVALID = 1'b0; S_ARREADY = 1'b0;
      slave_beat(32'hC000_0000 + t, 8'h13, 1'b1);
      #1;
      checks++; if (M1_RVALID !== 1'b1 || M1_RDATA !== (32'hC000_0000 + t)) begin errors++; $display("FAIL tie%0d_m1_beat got=%0h/%h exp=1/%h", t, M1_RVALID, M1_RDATA, 32'hC000_0000 + t); end
      tick();
      slave_idle();
      $display("txn tie%0d: M0 then M1 granted", t);
    end
  endtask

  task automatic test_backpressure();
    m0_beats.delete();
    M0_ARVALID = 1'b1; M0_ARID = 4'h1; M0_ARADDR = 32'h0000_0500; M0_ARLEN = 4'd1; M0_RREADY = 1'b0;
    tick();
    S_ARREADY = 1'b1;
    tick();
    M0_ARVALID = 1'b0; S_ARREADY = 1'b0;
    slave_beat(32'hD0D0_0000, 8'h01, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (S_RREADY !== 1'b0 || M0_RVALID !== 1'b1 || M0_RDATA !== 32'hD0D0_0000) begin
        errors++; $display("FAIL bp_stall%0d got=%0h/%0h/%h exp=0/1/d0d00000", c, S_RREADY, M0_RVALID, M0_RDATA); end
      tick();
    end
    M0_RREADY = 1'b1;
    #1;
    checks++; if (S_RREADY !== 1'b1) begin errors++; $display("FAIL bp_release got=%0h exp=1", S_RREADY); end
    tick();
    slave_beat(32'hD0D0_0001, 8'h01, 1'b1);
    #1;
    checks++; if (M0_RDATA !== 32'hD0D0_0001 || M0_RLAST !== 1'b1) begin errors++; $display("FAIL bp_beat2 got=%h/%0h exp=d0d00001/1", M0_RDATA, M0_RLAST); end
    tick();
    slave_idle();
    checks++; if (m0_beats.size() != 2) begin errors++; $display("FAIL bp_count got=%0d exp=2", m0_beats.size()); end
    else begin
      checks++; if (m0_beats[0] !== 32'hD0D0_0000 || m0_beats[1] !== 32'hD0D0_0001) begin
        errors++; $display("FAIL bp_order got=%h,%h exp=d0d00000,d0d00001", m0_beats[0], m0_beats[1]); end
    end
    $display("txn backpressure: M0 len=1 delivered %0d beats", m0_beats.size());
  endtask

  task automatic test_late_request();
    M0_ARVALID = 1'b1; M0_ARID = 4'h4; M0_ARLEN = 4'd1; M0_RREADY = 1'b1;
    M1_ARID = 4'h3; M1_ARLEN = 4'd0; M1_RREADY = 1'b1;
    tick();
    S_ARREADY = 1'b1;
    tick();
    M0_ARVALID = 1'b0; S_ARREADY = 1'b1;
    M1_ARVALID = 1'b1;
    for (int b = 0; b < 2; b++) begin
      slave_beat(32'hE000_0000 + b, 8'h04, (b == 1));
      #1;
      checks++; if (M1_ARREADY !== 1'b0 || S_ARVALID !== 1'b0) begin errors++; $display("FAIL late_held%0d got=%0h/%0h exp=0/0", b, M1_ARREADY, S_ARVALID); end
      tick();
    end
    slave_idle(); S_ARREADY = 1'b0;
    #1;
    checks++; if (M1_ARREADY !== 1'b0 || S_ARVALID !== 1'b0) begin errors++; $display("FAIL late_idle got=%0h/%0h exp=0/0", M1_ARREADY, S_ARVALID); end
    tick();
    checks++; if (S_ARVALID !== 1'b1 || S_ARID !== 8'h13) begin errors++; $display("FAIL late_grant got=%0h/%h exp=1/13", S_ARVALID, S_ARID); end
    S_ARREADY = 1'b1;
    tick();
    M1_ARVALID = 1'b0; S_ARREADY = 1'b0;
    slave_beat(32'hF000_0000, 8'h13, 1'b1);
    tick();
    slave_idle();
    $display("txn late_request: M1 granted after M0 burst");
  endtask

  task automatic test_reset_mid_burst();
    M0_ARVALID = 1'b1; M0_ARID = 4'h6; M0_ARLEN = 4'd7; M0_RREADY = 1'b1;
    tick();
    S_ARREADY = 1'b1;
    tick();
    M0_ARVALID = 1'b0; S_ARREADY = 1'b0;
    slave_beat(32'h7000_0000, 8'h06, 1'b0);
    tick();
    slave_beat(32'h7000_0001, 8'h06, 1'b0);
    #1;
    checks++; if (M0_RVALID !== 1'b1) begin errors++; $display("FAIL mid_beat2 got=%0h exp=1", M0_RVALID); end
    ARESETn = 1'b0;
    #1;
    checks++; if (M0_RVALID !== 1'b0 || S_RREADY !== 1'b0) begin errors++; $display("FAIL mid_async got=%0h/%0h exp=0/0", M0_RVALID, S_RREADY); end
    tick();
    ARESETn = 1'b1;
    tick();
    checks++; if (M0_RVALID !== 1'b0 || S_RREADY !== 1'b0 || S_ARVALID !== 1'b0) begin
      errors++; $display("FAIL mid_idle got=%0h/%0h/%0h exp=0/0/0", M0_RVALID, S_RREADY, S_ARVALID); end
    slave_idle();
    M0_ARVALID = 1'b1; M0_ARLEN = 4'd0;
    tick();
    checks++; if (S_ARVALID !== 1'b1 || S_ARID !== 8'h06) begin errors++; $display("FAIL mid_restart got=%0h/%h exp=1/06", S_ARVALID, S_ARID); end
    M0_ARVALID = 1'b0;
    $display("txn reset_mid_burst: aborted len=7 burst");
  endtask

  initial begin
    test_reset();
    test_single_m1();
    test_tie();
    test_backpressure();
    test_late_request();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Two-master AXI4 read-channel arbiter that shares the single AR/R port of the on-chip SRAM slave between instruction fetch (M0) and data access (M1). It sits between the CPU's two AXI read masters and the SRAM wrapper's slave read port. It grants one master at a time, forwards its address and burst, and routes the returned beats back to that master. Only one read transaction is in flight at a time. Write channels do not pass through this block.

## Interface
Parameters:
- ID_W, 4, master-side ID width
- IDS_W, 8, slave-side ID width; must be at least ID_W+1

Ports (clock and reset first):
- ACLK  in  1  system clock; all state updates on the rising edge
- ARESETn  in  1  asynchronous, active-low reset
- M0_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  ID_W/32/4/3/2/1  M0 read address channel
- M0_ARREADY  out  1  M0 address accepted
- M0_RID/RDATA/RRESP/RLAST/RVALID  out  ID_W/32/2/1/1  M0 read data channel
- M0_RREADY  in  1  M0 accepts data beat
- M1_*  same set as M0_*  data-side master
- S_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  IDS_W/32/4/3/2/1  to SRAM slave
- S_ARREADY  in  1  slave address accepted
- S_RID/RDATA/RRESP/RLAST/RVALID  in  IDS_W/32/2/1/1  from SRAM slave
- S_RREADY  out  1  to slave

## Operation
- FSM states: IDLE, ADDR, DATA. Registers: state, grant (1 bit), last_grant (1 bit).
- IDLE: if either Mx_ARVALID is high, the block latches grant and moves to ADDR.
  - Only one requester: that requester is granted.
  - Both requesting: round-robin; the master that is not last_grant wins.
  - Neither requesting: stay in IDLE.
- ADDR: passthrough for the granted master only.
  - S_ARVALID = Mgrant_ARVALID; Mgrant_ARREADY = S_ARREADY.
  - S_ARID = {zero-pad, grant, Mgrant_ARID}; bit ID_W of S_ARID carries the grant bit.
  - ADDR, LEN, SIZE and BURST are forwarded unchanged.
  - On the S_ARVALID & S_ARREADY handshake: update last_grant to grant and move to DATA.
- DATA: R channel passthrough to the granted master.
  - Mgrant_RVALID = S_RVALID; S_RREADY = Mgrant_RREADY.
  - Mgrant_RID = S_RID[ID_W-1:0]; RDATA, RRESP and RLAST are forwarded.
  - On S_RVALID & S_RREADY & S_RLAST: move to IDLE.
- Ungranted master, and both masters in IDLE: ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RID=0, RRESP=0.
- Slave side in IDLE: S_ARVALID=0, S_RREADY=0, and all S_AR* payload outputs are 0.
- Beat routing uses the grant register. A mismatch between S_RID[ID_W] and grant is ignored.
- If Mgrant_ARVALID drops during ADDR (an AXI violation), S_ARVALID follows it low and the FSM stays in ADDR.

## Timing
- Reset (async assert): state=IDLE, grant=0, last_grant=1 (so M0 wins the first tie). All outputs take their IDLE values immediately.
- Arbitration latency: request seen in IDLE at edge N; S_ARVALID rises after edge N (in the ADDR cycle).
- The master must hold ARVALID through this cycle, per AXI.
- Address and data passthrough are combinational, with zero added latency per beat.
- Each burst of ARLEN+1 beats completes on the beat where RLAST is handshaken.
- After the final beat there is at least one IDLE cycle before the next S_ARVALID.
- Back-to-back transactions therefore cost one bubble each.
- A request arriving during ADDR or DATA is held off (ARREADY=0) until the next IDLE evaluation.
- Back-pressure: RREADY low on the granted master stalls the slave with S_RREADY low. The beat stays visible, no beat is dropped, and the FSM stays in DATA.
- Reset asserted mid-burst: the FSM aborts to IDLE and outputs return to IDLE values asynchronously. No in-flight beat is delivered after reset.

## Test plan
- Reset: ARESETn low for 3 cycles, released while M0_ARVALID is high → all outputs 0 during reset; S_ARVALID rises the cycle after the first post-reset IDLE edge, with S_ARID[4]=0.
- Single M1 read: M1 ARADDR=0x0000_0040, ARLEN=3, ARID=2 → S_ARID=0x12 and S_ARADDR=0x40. 4 beats are routed to M1 with RID=2 and RLAST on beat 4. M0_RVALID stays 0 throughout.
- Simultaneous requests after reset: both masters request at the same cycle → M0 is granted first; M1 is granted after M0's RLAST plus one IDLE cycle. A repeated tie is then won by M0 again, since last_grant=M1.
- Back-pressure: M0 read with ARLEN=1 and M0_RREADY low for 5 cycles on beat 1 → S_RREADY stays 0 and RDATA is held stable. Both beats are delivered in order, with no duplication or loss.
- Late request: M1 asserts ARVALID during M0's DATA state → M1_ARREADY stays 0 until M0's RLAST handshake; M1 is granted in the following IDLE cycle.
- Reset mid-burst: assert ARESETn low on beat 2 of an ARLEN=7 burst → M0_RVALID=0 and S_RREADY=0 immediately; state is IDLE after release.
